// File: rtl/rsc_code_pkg.sv
// Shared definitions for the 8-state RSC constituent code (fb 1+D^2+D^3, ff 1+D+D^3)
// and the hard-decision Viterbi decoder built on it.
// No ports: block length, metric widths, FSM state type, path-metric vector type and
// the encoder next-state / parity helpers used by RTL and bench models.
package rsc_code_pkg;

  localparam int unsigned BLOCK_LEN       = 8;
  localparam int unsigned NUM_STATES      = 8;
  localparam int unsigned PM_W            = 6;
  localparam int unsigned PM_INIT_UNREACH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    FIND = 3'd2,
    TB   = 3'd3,
    DONE = 3'd4
  } dec_state_e;

  typedef logic [NUM_STATES-1:0][PM_W-1:0] pm_vec_t;

  // State 0 is the known encoder start; every other state starts out of reach.
  localparam pm_vec_t PM_INIT_VEC =
    {{(NUM_STATES-1){PM_W'(PM_INIT_UNREACH)}}, PM_W'(0)};

  // state = {s2, s1, s0}, s0 being the most recent register (D^1).
  function automatic logic [2:0] rsc_next_state(input logic [2:0] state, input logic u);
    logic a;
    a = u ^ state[1] ^ state[2];
    return {state[1], state[0], a};
  endfunction

  function automatic logic rsc_parity(input logic [2:0] state, input logic u);
    logic a;
    a = u ^ state[1] ^ state[2];
    return a ^ state[0] ^ state[2];
  endfunction

endpackage

// File: rtl/rsc_viterbi_decoder_if.sv
// Symbol-in / block-out handshake bundle of the RSC Viterbi decoder.
// Ports (signals): in_valid/in_ready/sym_sys/sym_par carry one received symbol,
// out_valid/out_ready/data_out/metric_out carry one decoded block.
// master = symbol producer and block consumer, slave = decoder.
interface rsc_viterbi_decoder_if;
  import rsc_code_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 sym_sys;
  logic                 sym_par;
  logic                 out_valid;
  logic                 out_ready;
  logic [BLOCK_LEN-1:0] data_out;
  logic [PM_W-1:0]      metric_out;

  modport master (
    output in_valid, sym_sys, sym_par, out_ready,
    input  in_ready, out_valid, data_out, metric_out
  );

  modport slave (
    input  in_valid, sym_sys, sym_par, out_ready,
    output in_ready, out_valid, data_out, metric_out
  );

endinterface

// File: rtl/rsc_acs_unit.sv
// Combinational add-compare-select over all 8 trellis states for one received symbol.
// Ports: pm_in (current path metrics), sym_sys/sym_par (hard symbol),
//        pm_out (updated metrics), surv (bit ns = q2 of the surviving predecessor of ns).
module rsc_acs_unit
  import rsc_code_pkg::*;
(
  input  pm_vec_t               pm_in,
  input  logic                  sym_sys,
  input  logic                  sym_par,
  output pm_vec_t               pm_out,
  output logic [NUM_STATES-1:0] surv
);

  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_state
    // Predecessors share q1 = ns2 and q0 = ns1; they differ only in q2.
    localparam logic [2:0] NS = 3'(ns);
    localparam logic [2:0] Q0 = {1'b0, NS[2:1]};
    localparam logic [2:0] Q1 = {1'b1, NS[2:1]};
    localparam logic       U0 = NS[0] ^ NS[2];
    localparam logic       U1 = ~U0;
    localparam logic       P0 = rsc_parity(Q0, U0);
    localparam logic       P1 = rsc_parity(Q1, U1);

    logic [1:0]      bm0;
    logic [1:0]      bm1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    assign bm0   = 2'(sym_sys != U0) + 2'(sym_par != P0);
    assign bm1   = 2'(sym_sys != U1) + 2'(sym_par != P1);
    assign cand0 = pm_in[Q0] + PM_W'(bm0);
    assign cand1 = pm_in[Q1] + PM_W'(bm1);

    // Strict compare: a tie keeps the q2=0 predecessor.
    assign surv[ns]   = (cand1 < cand0);
    assign pm_out[ns] = surv[ns] ? cand1 : cand0;
  end

endmodule

// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for one 8-state RSC constituent code.
// Collects BLOCK_LEN symbols with one ACS per handshake, picks the best end state,
// traces back one step per cycle and presents the data word plus winning metric.
// Ports: clk, reset (async, active-high),
//        bus (slave): in_valid/in_ready/sym_sys/sym_par in, out_valid/out_ready/data_out/metric_out out.
module rsc_viterbi_decoder
  import rsc_code_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  rsc_viterbi_decoder_if.slave bus
);

  dec_state_e            state;
  logic [2:0]            cnt;
  logic [2:0]            tb_k;
  logic [2:0]            tb_s;
  pm_vec_t               pm;
  pm_vec_t               pm_acs_in;
  pm_vec_t               pm_next;
  logic [NUM_STATES-1:0] surv_vec;
  logic [NUM_STATES-1:0] surv_mem [BLOCK_LEN];

  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [BLOCK_LEN-1:0] data_q;
  logic [PM_W-1:0]      metric_q;

  logic            hs;
  logic [PM_W-1:0] best_pm;
  logic [2:0]      best_s;
  logic            tb_b;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_q;
  assign bus.metric_out = metric_q;

  assign hs = bus.in_valid & in_ready_q;

  // The first ACS of a block starts from fresh metrics, not the previous block's.
  assign pm_acs_in = (state == IDLE) ? PM_INIT_VEC : pm;

  rsc_acs_unit u_acs (
    .pm_in   (pm_acs_in),
    .sym_sys (bus.sym_sys),
    .sym_par (bus.sym_par),
    .pm_out  (pm_next),
    .surv    (surv_vec)
  );

  // Minimum path metric; strict compare keeps the lowest index on ties.
  always_comb begin
    best_pm = pm[0];
    best_s  = 3'd0;
    for (int i = 1; i < int'(NUM_STATES); i++) begin
      if (pm[i] < best_pm) begin
        best_pm = pm[i];
        best_s  = 3'(i);
      end
    end
  end

  assign tb_b = surv_mem[tb_k][tb_s];

  // Control FSM with survivor storage and traceback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      tb_k        <= 3'd0;
      tb_s        <= 3'd0;
      pm          <= PM_INIT_VEC;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      metric_q    <= '0;
      for (int i = 0; i < int'(BLOCK_LEN); i++) begin
        surv_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (hs) begin
            pm          <= pm_next;
            surv_mem[0] <= surv_vec;
            cnt         <= 3'd1;
            state       <= ACC;
          end
        end
        ACC: begin
          if (hs) begin
            pm             <= pm_next;
            surv_mem[cnt]  <= surv_vec;
            cnt            <= cnt + 3'd1;
            if (cnt == 3'(BLOCK_LEN - 1)) begin
              in_ready_q <= 1'b0;
              state      <= FIND;
            end
          end
        end
        FIND: begin
          metric_q <= best_pm;
          tb_s     <= best_s;
          tb_k     <= 3'(BLOCK_LEN - 1);
          state    <= TB;
        end
        TB: begin
          // Predecessor is {b, s2, s1}; the input bit that led here is s0^s2^b.
          data_q[tb_k] <= tb_s[0] ^ tb_s[2] ^ tb_b;
          tb_s         <= {tb_b, tb_s[2], tb_s[1]};
          tb_k         <= tb_k - 3'd1;
          if (tb_k == 3'd0) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
